// File: rtl/multichannel_fir_filter.sv
// multichannel_fir_filter
//   Time-multiplexed FIR filter for CHANNELS interleaved voices sharing one
//   set of signed Q0.7 tap coefficients. The coefficients are read from an
//   external byte RAM (MemAddr/MemData/MemClk/MemWrite).
//
//   Optional build macro FIR_COEF_CACHE_EN: all taps are loaded into a local
//   register file once after reset. Per-sample processing then runs MAC
//   cycles back to back and does not access the RAM.
//
// Ports
//   Clock        system clock (rising edge)
//   Reset        asynchronous active-low reset
//   SampleValid  one-cycle input strobe
//   SampleIn     CHANNELS packed samples, channel c at [c*DATA_W +: DATA_W]
//   Ready        high when SampleValid will be accepted
//   WaveOut      filtered samples with the same packing; held between updates
//   OutValid     one-cycle strobe while WaveOut carries a new result
//   MemAddr      coefficient RAM address (holds outside FETCH_HI)
//   MemData      coefficient RAM read data
//   MemClk       RAM clock pulse (high for the FETCH_HI cycle)
//   MemWrite     RAM write enable, tied low
//   dbg_state_o  current FSM state
//
// Handshake: a sample transfers on a rising edge where SampleValid && Ready.
// SampleValid while Ready is low is ignored. OutValid is a strobe with no
// backpressure.
module multichannel_fir_filter #(
  parameter int DATA_W   = 24,
  parameter int COEF_W   = 8,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] COEF_BASE = 16'h8000
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         SampleValid,
  input  logic [CHANNELS*DATA_W-1:0]   SampleIn,
  output logic                         Ready,
  output logic [CHANNELS*DATA_W-1:0]   WaveOut,
  output logic                         OutValid,
  output logic [ADDR_W-1:0]            MemAddr,
  input  logic [COEF_W-1:0]            MemData,
  output logic                         MemClk,
  output logic                         MemWrite,
  output logic [2:0]                   dbg_state_o
);

  localparam int AW = DATA_W + COEF_W + $clog2(TAPS) + 1;
  localparam int PW = DATA_W + COEF_W;
  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    FETCH_HI = 3'd2,
    FETCH_LO = 3'd3,
    MAC      = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic [KW-1:0]              k_q, k_d;
  logic [CW-1:0]              c_q, c_d;
  logic                       mem_clk_q, mem_clk_d;
  logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
  logic signed [DATA_W-1:0]   x_q    [CHANNELS][TAPS];
  logic signed [AW-1:0]       acc_q  [CHANNELS];
  logic signed [AW-1:0]       acc_d  [CHANNELS];
  logic [DATA_W-1:0]          wave_q [CHANNELS];
  logic signed [COEF_W-1:0]   coef_sel;
  logic signed [PW-1:0]       prod;
  logic                       accept;

`ifdef FIR_COEF_CACHE_EN
  logic signed [COEF_W-1:0]   coef_rf_q [TAPS];
  logic                       loaded_q;
  assign Ready    = (state_q == IDLE) && loaded_q;
  assign coef_sel = coef_rf_q[k_q];
`else
  logic signed [COEF_W-1:0]   coef_q;
  assign Ready    = (state_q == IDLE);
  assign coef_sel = coef_q;
`endif

  assign accept      = Ready && SampleValid;
  assign OutValid    = (state_q == DONE);
  assign MemAddr     = mem_addr_q;
  assign MemClk      = mem_clk_q;
  assign MemWrite    = 1'b0;
  assign dbg_state_o = state_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign WaveOut[g*DATA_W +: DATA_W] = wave_q[g];
  end

  // Floor shift back to sample scale, then clamp. The value fits when all
  // bits from the sample sign bit upward agree.
  function automatic logic [DATA_W-1:0] sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> (COEF_W - 1);
    if ((&s[AW-1:DATA_W-1]) || !(|s[AW-1:DATA_W-1])) sat = s[DATA_W-1:0];
    else if (s[AW-1]) sat = {1'b1, {(DATA_W-1){1'b0}}};
    else              sat = {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    mem_clk_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      IDLE: begin
`ifdef FIR_COEF_CACHE_EN
        if (!loaded_q) begin
          state_d = FETCH_HI;
          k_d     = '0;
        end else if (SampleValid) begin
          state_d = SHIFT;
        end
`else
        if (SampleValid) state_d = SHIFT;
`endif
      end
      SHIFT: begin
        k_d = '0;
        c_d = '0;
`ifdef FIR_COEF_CACHE_EN
        state_d = MAC;
`else
        state_d = FETCH_HI;
`endif
      end
      FETCH_HI: state_d = FETCH_LO;
      FETCH_LO: begin
`ifdef FIR_COEF_CACHE_EN
        // Only reached during the post-reset load.
        if (k_q == K_LAST) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = FETCH_HI;
        end
`else
        c_d     = '0;
        state_d = MAC;
`endif
      end
      MAC: begin
        if (c_q == C_LAST) begin
          c_d = '0;
          if (k_q == K_LAST) begin
            state_d = DONE;
          end else begin
            k_d = k_q + KW'(1);
`ifdef FIR_COEF_CACHE_EN
            state_d = MAC;
`else
            state_d = FETCH_HI;
`endif
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // MemClk/MemAddr are registered so they are stable through FETCH_HI.
    if (state_d == FETCH_HI) begin
      mem_clk_d  = 1'b1;
      mem_addr_d = COEF_BASE + ADDR_W'(k_d);
    end
  end

  // MAC datapath: one channel per cycle, full-precision signed product.
  always_comb begin
    prod = PW'(x_q[c_q][k_q]) * PW'(coef_sel);
    for (int ch = 0; ch < CHANNELS; ch++) begin
      acc_d[ch] = acc_q[ch];
      if (state_q == SHIFT) acc_d[ch] = '0;
      else if (state_q == MAC && CW'(ch) == c_q) acc_d[ch] = acc_q[ch] + AW'(prod);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      c_q        <= '0;
      mem_clk_q  <= 1'b0;
      mem_addr_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        acc_q[ch]  <= '0;
        wave_q[ch] <= '0;
        for (int j = 0; j < TAPS; j++) x_q[ch][j] <= '0;
      end
`ifdef FIR_COEF_CACHE_EN
      loaded_q <= 1'b0;
      for (int j = 0; j < TAPS; j++) coef_rf_q[j] <= '0;
`else
      coef_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      c_q        <= c_d;
      mem_clk_q  <= mem_clk_d;
      mem_addr_q <= mem_addr_d;
      for (int ch = 0; ch < CHANNELS; ch++) acc_q[ch] <= acc_d[ch];
      // The delay lines shift on the accepting edge so SampleIn only has to
      // be valid alongside its strobe; SHIFT then clears the accumulators.
      if (accept) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          x_q[ch][0] <= SampleIn[ch*DATA_W +: DATA_W];
          for (int j = 1; j < TAPS; j++) x_q[ch][j] <= x_q[ch][j-1];
        end
      end
      if (state_q == FETCH_LO) begin
`ifdef FIR_COEF_CACHE_EN
        coef_rf_q[k_q] <= MemData;
        if (k_q == K_LAST) loaded_q <= 1'b1;
`else
        coef_q <= MemData;
`endif
      end
      // Load results on entry to DONE so WaveOut is valid with OutValid.
      if (state_q == MAC && state_d == DONE) begin
        for (int ch = 0; ch < CHANNELS; ch++) wave_q[ch] <= sat(acc_d[ch]);
      end
    end
  end

endmodule

// File: tb/tb_multichannel_fir_filter.sv
module tb_multichannel_fir_filter;

`ifdef FIR_COEF_CACHE_EN
  localparam int   EXP_LAT   = 18;
  localparam int   EXP_CLKS  = 0;
  localparam logic EXP_RDY_R = 1'b0;
`else
  localparam int   EXP_LAT   = 34;
  localparam int   EXP_CLKS  = 8;
  localparam logic EXP_RDY_R = 1'b1;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        SampleValid = 1'b0;
  logic [47:0] SampleIn = '0;
  logic        Ready;
  logic [47:0] WaveOut;
  logic        OutValid;
  logic [15:0] MemAddr;
  logic [7:0]  MemData;
  logic        MemClk;
  logic        MemWrite;
  logic [2:0]  dbg_state_o;

  logic [7:0]  coef_mem [8];
  int          checks = 0;
  int          errors = 0;
  int          memclk_cnt = 0;
  int          outvalid_cnt = 0;
  int          memwrite_bad = 0;

  multichannel_fir_filter dut (
    .Clock(Clock), .Reset(Reset), .SampleValid(SampleValid), .SampleIn(SampleIn),
    .Ready(Ready), .WaveOut(WaveOut), .OutValid(OutValid), .MemAddr(MemAddr),
    .MemData(MemData), .MemClk(MemClk), .MemWrite(MemWrite), .dbg_state_o(dbg_state_o)
  );

  // Clock / RAM model / monitors
  always #5 Clock = ~Clock;

  assign MemData = (MemAddr[15:3] == 13'h1000) ? coef_mem[MemAddr[2:0]] : 8'h00;

  always @(posedge MemClk) memclk_cnt++;
  always @(negedge Clock) if (OutValid === 1'b1) outvalid_cnt++;
  always @(negedge Clock) if (MemWrite !== 1'b0) memwrite_bad++;

  // Driver tasks
  task automatic set_coefs(input logic [63:0] c);
    for (int k = 0; k < 8; k++) coef_mem[k] = c[k*8 +: 8];
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    SampleValid = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (Ready !== 1'b1 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (Ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready: Ready=%b after %0d cycles, required 1", Ready, n);
    end
  endtask

  // Drives one sample (s0 ch0, s1 ch1) and waits for OutValid.
  // lat counts cycles from the accepting edge to the edge that samples OutValid.
  task automatic send_sample(input logic [23:0] s0, input logic [23:0] s1,
                             output int lat, output logic [47:0] wout);
    wait_ready();
    SampleIn = {s1, s0};
    SampleValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    SampleValid = 1'b0;
    SampleIn = '0;
    lat = 1;
    while (OutValid !== 1'b1 && lat < 200) begin
      @(negedge Clock);
      lat++;
    end
    wout = WaveOut;
    if (OutValid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: OutValid=%b after %0d cycles, required 1", OutValid, lat);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checks++; if (WaveOut !== 48'h0) begin errors++; $display("FAIL rst_waveout: got %h exp 0", WaveOut); end
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rst_outvalid: got %b exp 0", OutValid); end
    checks++; if (MemClk !== 1'b0) begin errors++; $display("FAIL rst_memclk: got %b exp 0", MemClk); end
    checks++; if (MemAddr !== 16'h0) begin errors++; $display("FAIL rst_memaddr: got %h exp 0", MemAddr); end
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite: got %b exp 0", MemWrite); end
    checks++; if (dbg_state_o !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", dbg_state_o); end
    checks++; if (Ready !== EXP_RDY_R) begin errors++; $display("FAIL rst_ready: got %b exp %b", Ready, EXP_RDY_R); end
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
`ifdef FIR_COEF_CACHE_EN
    begin
      int n = 0;
      while (Ready !== 1'b1 && n < 100) begin
        @(negedge Clock);
        n++;
      end
      checks++; if (n != 17) begin errors++; $display("FAIL cache_ready_rise: got %0d exp 17", n); end
    end
`else
    #1;
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", Ready); end
`endif
  endtask

  task automatic test_gain();
    int lat, clk0;
    logic [47:0] w;
    set_coefs(64'h0000_0000_0000_0040);
    do_reset();
    wait_ready();
    clk0 = memclk_cnt;
    send_sample(24'h100000, 24'hF00000, lat, w);
    checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL gain_latency: got %0d exp %0d", lat, EXP_LAT); end
    checks++; if (w[23:0] !== 24'h080000) begin errors++; $display("FAIL gain_ch0: got %h exp 080000", w[23:0]); end
    checks++; if (w[47:24] !== 24'hF80000) begin errors++; $display("FAIL gain_ch1: got %h exp f80000", w[47:24]); end
    checks++; if (memclk_cnt - clk0 != EXP_CLKS) begin errors++; $display("FAIL gain_memclk: got %0d exp %0d", memclk_cnt - clk0, EXP_CLKS); end
    @(negedge Clock);
    checks++; if (WaveOut !== 48'hF80000_080000) begin errors++; $display("FAIL gain_hold: got %h exp f80000080000", WaveOut); end
  endtask

  task automatic test_impulse();
    int lat;
    logic [47:0] w;
    logic [23:0] exp_imp [8];
    exp_imp = '{24'h200000, 24'h100000, 24'h080000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h3F8000};
    set_coefs(64'h7F00_0000_0010_2040);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_sample((i == 0) ? 24'h400000 : 24'h0, 24'h0, lat, w);
      checks++; if (w[23:0] !== exp_imp[i]) begin errors++; $display("FAIL impulse_ch0[%0d]: got %h exp %h", i, w[23:0], exp_imp[i]); end
      checks++; if (w[47:24] !== 24'h0) begin errors++; $display("FAIL impulse_ch1[%0d]: got %h exp 0", i, w[47:24]); end
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [47:0] w;
    set_coefs(64'h7F7F_7F7F_7F7F_7F7F);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_sample(24'h7FFFFF, 24'h800000, lat, w);
      if (i == 0) begin
        checks++; if (w !== 48'h810000_7EFFFF) begin errors++; $display("FAIL sat_first_pos: got %h exp 8100007effff", w); end
      end
      if (i == 7) begin
        checks++; if (w !== 48'h800000_7FFFFF) begin errors++; $display("FAIL sat_full_pos: got %h exp 8000007fffff", w); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      send_sample(24'h800000, 24'h7FFFFF, lat, w);
      if (i == 0) begin
        checks++; if (w !== 48'h800000_7FFFFF) begin errors++; $display("FAIL sat_mixed: got %h exp 8000007fffff", w); end
      end
      if (i == 7) begin
        checks++; if (w !== 48'h7FFFFF_800000) begin errors++; $display("FAIL sat_full_neg: got %h exp 7fffff800000", w); end
      end
    end
  endtask

  task automatic test_busy();
    int n, ov0, clk0, wr0, first_lat;
    logic [47:0] w;
    set_coefs(64'h0000_0000_0000_0040);
    do_reset();
    wait_ready();
    ov0 = outvalid_cnt;
    clk0 = memclk_cnt;
    wr0 = memwrite_bad;
    first_lat = -1;
    w = '0;
    SampleIn = {24'hF00000, 24'h100000};
    SampleValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    SampleValid = 1'b0;
    SampleIn = '0;
    n = 1;
    while (n < 80) begin
      if (n == 5) begin
        checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b exp 0", Ready); end
        SampleIn = {24'h7FFFFF, 24'h7FFFFF};
        SampleValid = 1'b1;
      end
      if (n == 6) begin
        SampleValid = 1'b0;
        SampleIn = '0;
      end
      if (OutValid === 1'b1 && first_lat < 0) begin
        first_lat = n;
        w = WaveOut;
      end
      @(negedge Clock);
      n++;
    end
    checks++; if (outvalid_cnt - ov0 != 1) begin errors++; $display("FAIL busy_outvalid_count: got %0d exp 1", outvalid_cnt - ov0); end
    checks++; if (first_lat != EXP_LAT) begin errors++; $display("FAIL busy_latency: got %0d exp %0d", first_lat, EXP_LAT); end
    checks++; if (w !== 48'hF80000_080000) begin errors++; $display("FAIL busy_result: got %h exp f80000080000", w); end
    checks++; if (memclk_cnt - clk0 != EXP_CLKS) begin errors++; $display("FAIL busy_memclk: got %0d exp %0d", memclk_cnt - clk0, EXP_CLKS); end
    checks++; if (memwrite_bad - wr0 != 0) begin errors++; $display("FAIL busy_memwrite: got %0d exp 0", memwrite_bad - wr0); end
  endtask

  task automatic test_reset_abort();
    int lat, ov0;
    logic [47:0] w;
    set_coefs(64'h0000_0000_0000_4040);
    do_reset();
    send_sample(24'h100000, 24'h200000, lat, w);
    checks++; if (w !== 48'h100000_080000) begin errors++; $display("FAIL abort_pre: got %h exp 100000080000", w); end
    wait_ready();
    SampleIn = {24'h300000, 24'h300000};
    SampleValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    SampleValid = 1'b0;
    SampleIn = '0;
    repeat (19) @(negedge Clock);
    Reset = 1'b0;
    #1;
    checks++; if (WaveOut !== 48'h0) begin errors++; $display("FAIL abort_waveout: got %h exp 0", WaveOut); end
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL abort_outvalid: got %b exp 0", OutValid); end
    checks++; if (Ready !== EXP_RDY_R) begin errors++; $display("FAIL abort_ready: got %b exp %b", Ready, EXP_RDY_R); end
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    ov0 = outvalid_cnt;
    repeat (60) @(negedge Clock);
    checks++; if (outvalid_cnt != ov0) begin errors++; $display("FAIL abort_no_outvalid: got %0d exp 0", outvalid_cnt - ov0); end
    // Tap 1 is nonzero, so leftover history would show up here.
    send_sample(24'h040000, 24'hFC0000, lat, w);
    checks++; if (w !== 48'hFE0000_020000) begin errors++; $display("FAIL abort_fresh: got %h exp fe0000020000", w); end
  endtask

  initial begin
    set_coefs(64'h0);
    test_reset();
    test_gain();
    test_impulse();
    test_saturation();
    test_busy();
    test_reset_abort();
    checks++;
    if (memwrite_bad != 0) begin errors++; $display("FAIL memwrite_total: got %0d exp 0", memwrite_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
